sigmul_iter: RTL and testbench

Iterative, parametrised significand multiplier, replacing the single-cycle shift-add array in the FP multiply datapath. It retires K multiplier bits per clock into an accumulator, trading latency for area, and uses valid/ready handshakes on both sides so the FP pipeline can stall it. The result is the exact 2·(NSIG+1)-bit unsigned product, ready for normalisation and rounding downstream.

---
 rtl/sigmul_pkg.sv | 19 +
 rtl/sigmul_pp.sv | 18 +
 rtl/sigmul_iter.sv | 103 ++++++++++
 tb/tb_sigmul_iter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigmul_pkg.sv
// sigmul_pkg: FSM state type and sizing helpers for the iterative
// significand multiplier.
package sigmul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  function automatic int niter_f(input int nsig, input int k);
    return (nsig + k) / k;
  endfunction

  function automatic int cnt_w_f(input int nsig, input int k);
    return $clog2(niter_f(nsig, k) + 1);
  endfunction

endpackage

// File: rtl/sigmul_pp.sv
// sigmul_pp: combinational K-bit partial product, a * b[K-1:0].
// Sized NSIG+1+K so no product bit is ever lost.
module sigmul_pp #(
  parameter int NSIG = 10,
  parameter int K    = 2
) (
  input  logic [NSIG:0]   a,
  input  logic [K-1:0]    b,
  output logic [NSIG+K:0] pp
);

  localparam int PW = NSIG + 1 + K;

  always_comb begin
    pp = PW'(a) * PW'(b);
  end

endmodule

// File: rtl/sigmul_iter.sv
// sigmul_iter: iterative significand multiplier, K multiplier bits per cycle.
// Optional SIGMUL_ZERO_SKIP_EN ends BUSY once the remaining multiplier is zero.
import sigmul_pkg::*;

module sigmul_iter #(
  parameter int NSIG = 10,
  parameter int K    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NSIG:0]     a,
  input  logic [NSIG:0]     b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*NSIG+1:0] p,
  output logic              busy
);

  localparam int NITER = niter_f(NSIG, K);
  localparam int CNTW  = cnt_w_f(NSIG, K);
  localparam int BW    = NITER * K;
  localparam int ACCW  = 2 * NSIG + 2;
  localparam int PW    = NSIG + 1 + K;
  localparam logic [CNTW-1:0] LAST = CNTW'(NITER - 1);

  state_e            state_q, state_d;
  logic [NSIG:0]     a_q, a_d;
  logic [BW-1:0]     b_q, b_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]     pp;
  logic [ACCW-1:0]   pp_sh;
  logic              accept;

  sigmul_pp #(
    .NSIG(NSIG),
    .K   (K)
  ) u_pp (
    .a (a_q),
    .b (b_q[K-1:0]),
    .pp(pp)
  );

  always_comb begin
    in_ready  = (state_q == IDLE) ||
                ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
    busy      = (state_q == BUSY);
    p         = acc_q;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    accept  = in_valid && in_ready;
    pp_sh   = ACCW'(pp) << (int'(cnt_q) * K);
    unique case (state_q)
      BUSY: begin
        acc_d = acc_q + pp_sh;
        b_d   = b_q >> K;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
`ifdef SIGMUL_ZERO_SKIP_EN
        if (b_d == '0) state_d = DONE;
`endif
      end
      DONE: begin
        if (out_ready && !in_valid) state_d = IDLE;
      end
      default: ;
    endcase
    // New operands win over any other transition (zero-bubble handoff)
    if (accept) begin
      a_d     = a;
      b_d     = BW'(b);
      acc_d   = '0;
      cnt_d   = '0;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sigmul_iter.sv
// tb_sigmul_iter: randomized self-checking bench for sigmul_iter,
// compared against plain a*b and a latency model.
module tb_sigmul_iter;

  localparam int NSIG = 10;
  localparam int W    = NSIG + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [10:0] a = '0;
  logic [10:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [21:0] p;

  logic        k_iv = 1'b0;
  logic        k_or = 1'b1;
  logic [10:0] ka = '0;
  logic [10:0] kb = '0;
  logic        k1_ir, k1_ov, k1_busy;
  logic [21:0] k1_p;
  logic        k11_ir, k11_ov, k11_busy;
  logic [21:0] k11_p;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sigmul_iter #(.NSIG(10), .K(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p        (p),
    .busy     (busy)
  );

  sigmul_iter #(.NSIG(10), .K(1)) dut_k1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (k_iv),
    .in_ready (k1_ir),
    .a        (ka),
    .b        (kb),
    .out_valid(k1_ov),
    .out_ready(k_or),
    .p        (k1_p),
    .busy     (k1_busy)
  );

  sigmul_iter #(.NSIG(10), .K(11)) dut_k11 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (k_iv),
    .in_ready (k11_ir),
    .a        (ka),
    .b        (kb),
    .out_valid(k11_ov),
    .out_ready(k_or),
    .p        (k11_p),
    .busy     (k11_busy)
  );

  function automatic logic [21:0] model_p(input logic [10:0] av,
                                          input logic [10:0] bv);
    return {11'b0, av} * {11'b0, bv};
  endfunction

  function automatic int exp_lat(input int bv, input int k);
`ifdef SIGMUL_ZERO_SKIP_EN
    int msb;
    if (bv == 0) return 1;
    msb = 0;
    for (int i = 0; i < W; i++) if (bv[i]) msb = i;
    return (msb + k) / k;
`else
    if (bv < 0) return 0;
    return (NSIG + k) / k;
`endif
  endfunction

  task automatic run_op(input logic [10:0] av, input logic [10:0] bv,
                        output logic [21:0] pr, output int lat);
    int n;
    a = av;
    b = bv;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 11'($urandom);
    b = 11'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    pr = p;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== '0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b p=%h, want 1 0 0 0",
               in_ready, out_valid, busy, p);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed(input string nm, input logic [10:0] av,
                               input logic [10:0] bv);
    logic [21:0] pr;
    int lat;
    run_op(av, bv, pr, lat);
    n_chk++;
    if (pr !== model_p(av, bv)) begin
      n_fail++;
      $display("FAIL %s product: got %h want %h", nm, pr, model_p(av, bv));
    end
    n_chk++;
    if (lat != exp_lat(int'(bv), 2)) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat(int'(bv), 2));
    end
    handshake();
  endtask

  task automatic test_backpressure();
    logic [21:0] pr, e;
    int lat;
    e = model_p(11'h5A5, 11'h3C3);
    run_op(11'h5A5, 11'h3C3, pr, lat);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (p !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure hold %0d: p=%h ov=%b ir=%b want p=%h ov=1 ir=0",
                 i, p, out_valid, in_ready, e);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure in_ready follows out_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure idle: ov=%b busy=%b ir=%b want 0 0 1",
               out_valid, busy, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] av[3];
    logic [10:0] bv[3];
    int rcyc[3];
    int idx, nres, cyc;
    bit acc_now;
    for (int i = 0; i < 3; i++) begin
      av[i] = 11'($urandom);
      bv[i] = 11'h400 | 11'($urandom_range(0, 1023));
    end
    idx = 0;
    nres = 0;
    cyc = 0;
    a = av[0];
    b = bv[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (nres < 3 && cyc < 100) begin
      acc_now = in_valid && in_ready;
      if (out_valid) begin
        n_chk++;
        if (p !== model_p(av[nres], bv[nres])) begin
          n_fail++;
          $display("FAIL b2b result %0d: got %h want %h",
                   nres, p, model_p(av[nres], bv[nres]));
        end
        rcyc[nres] = cyc;
        nres++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc_now) begin
        idx++;
        if (idx < 3) begin
          a = av[idx];
          b = bv[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_chk++;
    if (nres != 3 || idx != 3) begin
      n_fail++;
      $display("FAIL b2b count: results=%0d accepts=%0d want 3 3", nres, idx);
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_chk++;
        if (rcyc[i] - rcyc[i-1] != 7) begin
          n_fail++;
          $display("FAIL b2b spacing %0d: got %0d want 7", i, rcyc[i] - rcyc[i-1]);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [10:0] av, bv;
    av = 11'h6B3;
    bv = 11'h7A1;
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid busy before reset: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || p !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid async: ov=%b ir=%b p=%h busy=%b want 0 1 0 0",
               out_valid, in_ready, p, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed("after_reset", 11'h2D9, 11'h5E7);
  endtask

  task automatic test_zero_skip();
    test_directed("b_one", 11'h3A5, 11'h001);
    test_directed("b_zero", 11'h7FF, 11'h000);
    test_directed("b_small", 11'h123, 11'h00D);
  endtask

  task automatic test_k_edges();
    for (int it = 0; it < 3; it++) begin
      int l1, l11, cyc;
      logic [21:0] p1, p11, e;
      l1 = -1;
      l11 = -1;
      cyc = 0;
      p1 = '0;
      p11 = '0;
      ka = 11'($urandom);
      kb = (it == 0) ? (11'h400 | 11'($urandom_range(0, 1023))) : 11'($urandom);
      e = model_p(ka, kb);
      k_iv = 1'b1;
      @(posedge clk); #1;
      k_iv = 1'b0;
      while ((l1 < 0 || l11 < 0) && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
        if (k1_ov && l1 < 0) begin
          l1 = cyc;
          p1 = k1_p;
        end
        if (k11_ov && l11 < 0) begin
          l11 = cyc;
          p11 = k11_p;
        end
      end
      @(posedge clk); #1;
      n_chk++;
      if (p1 !== e || l1 != exp_lat(int'(kb), 1)) begin
        n_fail++;
        $display("FAIL k1 op %0d: p=%h lat=%0d want p=%h lat=%0d",
                 it, p1, l1, e, exp_lat(int'(kb), 1));
      end
      n_chk++;
      if (p11 !== e || l11 != exp_lat(int'(kb), 11)) begin
        n_fail++;
        $display("FAIL k11 op %0d: p=%h lat=%0d want p=%h lat=%0d",
                 it, p11, l11, e, exp_lat(int'(kb), 11));
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [10:0] av, bv;
    logic [21:0] pr;
    int lat;
    for (int i = 0; i < n; i++) begin
      av = 11'($urandom);
      bv = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(0, 3)) : 11'($urandom);
      run_op(av, bv, pr, lat);
      n_chk++;
      if (pr !== model_p(av, bv) || lat != exp_lat(int'(bv), 2)) begin
        n_fail++;
        $display("FAIL random %0d a=%h b=%h: p=%h lat=%0d want p=%h lat=%0d",
                 i, av, bv, pr, lat, model_p(av, bv), exp_lat(int'(bv), 2));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_directed("nominal", 11'h400, 11'h400);
    test_directed("max", 11'h7FF, 11'h7FF);
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_zero_skip();
    test_k_edges();
    test_random(1500);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
